// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel button conditioning for raw board pins.
// Each channel synchronizes its raw level through two flops. It then
// debounces the level with a stable-cycle counter, and emits one-cycle edge
// pulses when a new level is accepted.
//
// Parameters
//   WIDTH            number of independent button channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (2..2^24)
// Ports
//   clk_i    clock, all state on rising edge
//   reset_i  synchronous active-high reset
//   btn_i    raw asynchronous button levels [WIDTH]
//   level_o  debounced level [WIDTH]
//   rise_o   one-cycle pulse on accepted 0->1 [WIDTH]
//   fall_o   one-cycle pulse on accepted 1->0 [WIDTH]

// One channel: 2-flop synchronizer, debounce counter, registered edge pulses.
module btn_conditioner_chan #(
  parameter int unsigned D  = 4,
  parameter int unsigned CW = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CW-1:0] CNT_MAX = CW'(D - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        // any return to the accepted level throws away the partial count
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end else begin
        // D-th consecutive mismatching cycle: accept; pulse lands with level
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end
    end
  end
endmodule

module btn_conditioner #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_conditioner_chan #(
      .D  (DEBOUNCE_CYCLES),
      .CW (CW)
    ) u_ch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn     (btn_i[i]),
      .level   (level_o[i]),
      .rise    (rise_o[i]),
      .fall    (fall_o[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (WIDTH=3, D=4): directed table of
// {reset, btn, expected outputs}, then randomized stimulus against a
// history-window reference model.
module tb_btn_conditioner;
  localparam int W = 3;
  localparam int D = 4;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] btn_i = '0;
  logic [W-1:0] level_o, rise_o, fall_o;

  btn_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         rst;
    logic [W-1:0] btn;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the level seen by the debouncer at an edge is the raw
  // input sampled two edges earlier. A channel flips when its last D seen
  // values all differ from its current level.
  logic [W-1:0] pipe[$] = '{'0, '0};
  logic [W-1:0] seen[$];
  logic [W-1:0] m_lvl = '0, m_rise = '0, m_fall = '0;

  task automatic model_edge(input logic r, input logic [W-1:0] b);
    logic [W-1:0] s;
    bit           flip;
    if (r) begin
      pipe   = '{'0, '0};
      seen   = {};
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(b);
      seen.push_back(s);
      if (seen.size() > D) void'(seen.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < W; c++) begin
        flip = (seen.size() == D);
        foreach (seen[k]) if (seen[k][c] == m_lvl[c]) flip = 0;
        if (flip) begin
          m_lvl[c]  = ~m_lvl[c];
          m_rise[c] = m_lvl[c];
          m_fall[c] = ~m_lvl[c];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] b);
    @(negedge clk_i);
    reset_i = r;
    btn_i   = b;
    @(posedge clk_i);
    model_edge(r, b);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] l,
                       input logic [W-1:0] ri, input logic [W-1:0] fa);
    n_vec++;
    if (level_o !== l || rise_o !== ri || fall_o !== fa) begin
      n_err++;
      $display("FAIL %s: got level=%b rise=%b fall=%b, want level=%b rise=%b fall=%b",
               name, level_o, rise_o, fall_o, l, ri, fa);
    end
  endtask

  task automatic add(input logic r, input logic [W-1:0] b, input logic [W-1:0] l,
                     input logic [W-1:0] ri, input logic [W-1:0] fa, input int reps = 1);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = l; v.rise = ri; v.fall = fa;
    for (int i = 0; i < reps; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] b;
    logic         r;

    // reset with all buttons held
    add(1, 3'b111, 3'b000, 3'b000, 3'b000, 2);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 2);
    // clean press ch0: sampled at edge n, accepted after edge n+1+D
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 2);
    // bounce ch1: 3 high, 2 low (counter reaches D-1 then clears), then held
    add(0, 3'b011, 3'b001, 3'b000, 3'b000, 3);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 2);
    add(0, 3'b011, 3'b001, 3'b000, 3'b000, 5);
    add(0, 3'b011, 3'b011, 3'b010, 3'b000);
    add(0, 3'b011, 3'b011, 3'b000, 3'b000);
    // press ch2, then release it
    add(0, 3'b111, 3'b011, 3'b000, 3'b000, 5);
    add(0, 3'b111, 3'b111, 3'b100, 3'b000);
    add(0, 3'b111, 3'b111, 3'b000, 3'b000);
    add(0, 3'b011, 3'b111, 3'b000, 3'b000, 5);
    add(0, 3'b011, 3'b011, 3'b000, 3'b100);
    add(0, 3'b011, 3'b011, 3'b000, 3'b000);
    // release ch0/ch1 together, then simultaneous press of ch0/ch2
    add(0, 3'b000, 3'b011, 3'b000, 3'b000, 5);
    add(0, 3'b000, 3'b000, 3'b000, 3'b011);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b101, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b101, 3'b101, 3'b101, 3'b000);
    add(0, 3'b101, 3'b101, 3'b000, 3'b000, 2);
    // reset mid-count: 3 counting cycles on ch0, 1-cycle reset, button held
    add(1, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(1, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 2);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn);
      check($sformatf("dir%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall);
    end

    // random: sparse toggles so both accepted changes and bounces occur
    b = '0;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
      r = ($urandom_range(0, 299) == 0);
      step(r, b);
      check($sformatf("rnd%0d", t), m_lvl, m_rise, m_fall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
